// File: rtl/bmp_pixel_reader.sv
// Reads a bottom-up, BGR, row-padded 24-bit BMP pixel array and streams top-down RGB pixels.
// Optional row-padding check: define BMP_READER_PADDING_CHECK_EN.
module bmp_pixel_reader #(
  parameter int DATA_OFFSET = 54,
  parameter int DIM_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [31:0]      readAddr,
  input  logic [15:0]      readdata,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [7:0]       pix_r,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_b,
  output logic [DIM_W-1:0] pix_x,
  output logic [DIM_W-1:0] pix_y,
  output logic             pix_eol,
  output logic             pix_last,
  output logic             done,
  output logic             pad_err
);

  localparam int SW = DIM_W + 2;
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_CAP     = 3'd2;
  localparam logic [2:0] S_OUT     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
`ifdef BMP_READER_PADDING_CHECK_EN
  localparam logic [2:0] S_PAD_RD  = 3'd5;
  localparam logic [2:0] S_PAD_CAP = 3'd6;
`endif

  // Byte address of the first byte of output row y (BMP stores rows bottom-up).
  function automatic logic [31:0] row_base(input logic [DIM_W-1:0] w,
                                           input logic [DIM_W-1:0] h,
                                           input logic [DIM_W-1:0] y);
    logic [SW-1:0] stride;
    stride = ({2'b00, w} * SW'(3) + SW'(3)) & ~SW'(3);
    return 32'(DATA_OFFSET) + (32'(h) - 32'd1 - 32'(y)) * 32'(stride);
  endfunction

  function automatic logic [31:0] pix_addr(input logic [DIM_W-1:0] w,
                                           input logic [DIM_W-1:0] h,
                                           input logic [DIM_W-1:0] x,
                                           input logic [DIM_W-1:0] y,
                                           input logic [1:0]       k);
    return row_base(w, h, y) + 32'(x) * 32'd3 + 32'(k);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]       k_q, k_d;
  logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic [31:0]      addr_q, addr_d;
  logic             eol_w, last_w;
  logic             unused_hi;

`ifdef BMP_READER_PADDING_CHECK_EN
  logic [31:0]      pad_base_q, pad_base_d;
  logic             pad_last_q, pad_last_d;
  logic             pad_err_q, pad_err_d;
  logic [1:0]       pad_n;
  // stride - 3*width reduces to width mod 4
  assign pad_n = w_q[1:0];
`endif

  assign eol_w  = (x_q == w_q - DIM_ONE);
  assign last_w = eol_w && (y_q == h_q - DIM_ONE);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    addr_d  = addr_q;
`ifdef BMP_READER_PADDING_CHECK_EN
    pad_base_d = pad_base_q;
    pad_last_d = pad_last_q;
    pad_err_d  = pad_err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_d = width;
          h_d = height;
          x_d = '0;
          y_d = '0;
          k_d = 2'd0;
`ifdef BMP_READER_PADDING_CHECK_EN
          pad_err_d = 1'b0;
`endif
          if (width == '0 || height == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            addr_d  = pix_addr(width, height, '0, '0, 2'd0);
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        case (k_q)
          2'd0:    b_d = readdata[7:0];
          2'd1:    g_d = readdata[7:0];
          default: r_d = readdata[7:0];
        endcase
        if (k_q < 2'd2) begin
          k_d     = k_q + 2'd1;
          state_d = S_RD;
          addr_d  = pix_addr(w_q, h_q, x_q, y_q, k_q + 2'd1);
        end else begin
          k_d     = 2'd0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (pix_ready) begin
          if (last_w) begin
            state_d = S_DONE;
          end else if (eol_w) begin
            x_d     = '0;
            y_d     = y_q + DIM_ONE;
            state_d = S_RD;
            addr_d  = pix_addr(w_q, h_q, '0, y_q + DIM_ONE, 2'd0);
          end else begin
            x_d     = x_q + DIM_ONE;
            state_d = S_RD;
            addr_d  = pix_addr(w_q, h_q, x_q + DIM_ONE, y_q, 2'd0);
          end
`ifdef BMP_READER_PADDING_CHECK_EN
          // Detour through the pad bytes of the row just finished; x/y already advanced.
          if (eol_w && pad_n != 2'd0) begin
            state_d    = S_PAD_RD;
            k_d        = 2'd0;
            pad_last_d = last_w;
            pad_base_d = row_base(w_q, h_q, y_q) + 32'(w_q) * 32'd3;
            addr_d     = row_base(w_q, h_q, y_q) + 32'(w_q) * 32'd3;
          end
`endif
        end
      end
`ifdef BMP_READER_PADDING_CHECK_EN
      S_PAD_RD: state_d = S_PAD_CAP;
      S_PAD_CAP: begin
        if (readdata[7:0] != 8'd0) pad_err_d = 1'b1;
        if (k_q == pad_n - 2'd1) begin
          k_d = 2'd0;
          if (pad_last_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            addr_d  = pix_addr(w_q, h_q, x_q, y_q, 2'd0);
          end
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_PAD_RD;
          addr_d  = pad_base_q + 32'(k_q + 2'd1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= 2'd0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
      addr_q  <= 32'd0;
`ifdef BMP_READER_PADDING_CHECK_EN
      pad_base_q <= 32'd0;
      pad_last_q <= 1'b0;
      pad_err_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
`ifdef BMP_READER_PADDING_CHECK_EN
      pad_base_q <= pad_base_d;
      pad_last_q <= pad_last_d;
      pad_err_q  <= pad_err_d;
`endif
    end
  end

  assign readAddr  = addr_q;
  assign pix_valid = (state_q == S_OUT);
  assign pix_r     = r_q;
  assign pix_g     = g_q;
  assign pix_b     = b_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_eol   = pix_valid && eol_w;
  assign pix_last  = pix_valid && last_w;
  assign done      = (state_q == S_DONE);
`ifdef BMP_READER_PADDING_CHECK_EN
  assign pad_err   = pad_err_q;
`else
  assign pad_err   = 1'b0;
`endif
  assign unused_hi = ^readdata[15:8];

endmodule

// File: tb/tb_bmp_pixel_reader.sv
// Randomized bench for bmp_pixel_reader against a raster-order reference model of the BMP layout.
module tb_bmp_pixel_reader;
  localparam int DOFF = 54;
  localparam int DW   = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] width = '0;
  logic [DW-1:0] height = '0;
  logic [31:0]   readAddr;
  logic [15:0]   readdata = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [7:0]    pix_r, pix_g, pix_b;
  logic [DW-1:0] pix_x, pix_y;
  logic          pix_eol, pix_last, done, pad_err;

  logic [7:0] mem [0:4095];
  int n_checks = 0;
  int n_errors = 0;

  bmp_pixel_reader #(.DATA_OFFSET(DOFF), .DIM_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .width(width), .height(height),
    .readAddr(readAddr), .readdata(readdata), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
    .pix_eol(pix_eol), .pix_last(pix_last), .done(done), .pad_err(pad_err)
  );

  always #5 clk = ~clk;

  // One-cycle memory; the high byte is noise the reader must ignore.
  always @(posedge clk) readdata <= {8'($urandom), mem[readAddr[11:0]]};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int stride_of(input int w);
    return ((3 * w + 3) / 4) * 4;
  endfunction

  function automatic logic [63:0] pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                       input int x, input int y, input logic eol, input logic last);
    return {16'd0, r, g, b, DW'(x), DW'(y), eol, last};
  endfunction

  function automatic logic [63:0] dut_pix();
    return pack(pix_r, pix_g, pix_b, int'(pix_x), int'(pix_y), pix_eol, pix_last);
  endfunction

  function automatic bit addr_ok(input logic [31:0] a, input int w, input int h);
    int o, s;
    if (a < 32'(DOFF)) return 1'b0;
    o = int'(a) - DOFF;
    s = stride_of(w);
    if (o >= h * s) return 1'b0;
`ifdef BMP_READER_PADDING_CHECK_EN
    return 1'b1;
`else
    return (o % s) < 3 * w;
`endif
  endfunction

  task automatic fill_frame(input int w, input int h);
    int s;
    s = stride_of(w);
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int y = 0; y < h; y++)
      for (int c = 3 * w; c < s; c++) mem[DOFF + y * s + c] = 8'd0;
  endtask

  task automatic run_frame(input int w, input int h, input int ready_pct, input int stall_first,
                           input bit check_lat, input bit exp_pad);
    logic [63:0] exp_q[$];
    logic [63:0] e;
    int s, a, n, cyc, first, got, stalls, bad, budget, waited;
    s = stride_of(w);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        a = DOFF + (h - 1 - y) * s + 3 * x;
        exp_q.push_back(pack(mem[a + 2], mem[a + 1], mem[a], x, y, x == w - 1,
                             (x == w - 1) && (y == h - 1)));
      end
    n = w * h;
    @(negedge clk);
    width = DW'(w);
    height = DW'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    width = DW'($urandom);
    height = DW'($urandom);
    check_eq("done_drop", 64'(done), 64'd0);
    cyc = 0; first = -1; got = 0; stalls = 0; bad = 0;
    budget = 200 + 60 * n;
    while (got < n && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!addr_ok(readAddr, w, h)) bad++;
      pix_ready = 1'b0;
      if (pix_valid) begin
        if (first < 0) first = cyc;
        e = exp_q[0];
        check_eq("pix", dut_pix(), e);
        if (stalls < stall_first) stalls++;
        else if (int'($urandom_range(99)) < ready_pct) begin
          pix_ready = 1'b1;
          $display("pix w=%0d h=%0d x=%0d y=%0d rgb=%02h%02h%02h eol=%0b last=%0b",
                   w, h, pix_x, pix_y, pix_r, pix_g, pix_b, pix_eol, pix_last);
          void'(exp_q.pop_front());
          got++;
        end
      end
    end
    waited = 0;
    while (!done && waited < 12) begin
      @(posedge clk);
      #1;
      pix_ready = 1'b0;
      waited++;
    end
    check_eq("pix_count", 64'(got), 64'(n));
    check_eq("frame_done", 64'(done), 64'd1);
    check_eq("valid_after_done", 64'(pix_valid), 64'd0);
    check_eq("addr_range", 64'(bad), 64'd0);
    check_eq("pad_err", 64'(pad_err), 64'(exp_pad));
    if (check_lat) check_eq("first_latency", 64'(first), 64'd6);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h, bad;
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_valid", 64'(pix_valid), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_addr", 64'(readAddr), 64'd0);
    check_eq("reset_pix", dut_pix(), 64'd0);
    check_eq("reset_pad", 64'(pad_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero width/height: straight to done without touching memory.
    @(negedge clk);
    width = DW'(0);
    height = DW'(3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("zero_done", 64'(done), 64'd1);
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (pix_valid || readAddr != 32'd0) bad++;
    end
    check_eq("zero_quiet", 64'(bad), 64'd0);
    $display("zero-dim frame w=0 h=3 done=%0b", done);

    // Directed 2x2 frame, stride 8.
    for (int i = 54; i < 60; i++) mem[i] = 8'(i - 53);
    for (int i = 62; i < 68; i++) mem[i] = 8'(i - 62 + 8'h11);
    run_frame(2, 2, 100, 0, 1, 0);
    run_frame(1, 1, 100, 0, 1, 0);

    // Reset in the middle of a pixel fetch, then a clean restart.
    @(negedge clk);
    width = DW'(2);
    height = DW'(2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(pix_valid), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_addr", 64'(readAddr), 64'd0);
    check_eq("midrst_pix", dut_pix(), 64'd0);
    $display("mid-frame reset applied");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(2, 2, 100, 0, 1, 0);

    fill_frame(4, 1);
    run_frame(4, 1, 100, 5, 1, 0);

    for (int t = 0; t < 8; t++) begin
      w = int'($urandom_range(1, 7));
      h = int'($urandom_range(1, 5));
      fill_frame(w, h);
      run_frame(w, h, int'($urandom_range(30, 100)), int'($urandom_range(0, 3)), 1, 0);
    end

`ifdef BMP_READER_PADDING_CHECK_EN
    fill_frame(1, 1);
    mem[57] = 8'hAA;
    run_frame(1, 1, 100, 0, 1, 1);
    mem[57] = 8'h00;
    run_frame(1, 1, 100, 0, 1, 0);
    fill_frame(3, 3);
    mem[DOFF + 9] = 8'h01;
    run_frame(3, 3, 70, 0, 1, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bmp_pixel_reader.md
Name: bmp_pixel_reader

Overview:
- Reads back a cropped 24-bit BMP pixel array that the cropping block has already written to memory.
- Strips row padding, undoes BMP bottom-up row order and BGR byte order, and emits top-down raster RGB pixels on a valid/ready stream.
- Sits between the frame memory and downstream pixel consumers (display/analysis).

Parameters:
- DATA_OFFSET, 54, byte address of first pixel-array byte (after BMP header)
- DIM_W, 11, width of width/height/coordinate fields

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin frame readout (sampled in IDLE or DONE)
- width  in  DIM_W  cropped image width in pixels, sampled on accepted start
- height  in  DIM_W  cropped image height in pixels, sampled on accepted start
- readAddr  out  32  memory byte address
- readdata  in  16  memory data; bits [7:0] valid exactly 1 cycle after readAddr presented
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts pixel
- pix_r, pix_g, pix_b  out  8 each  pixel colour
- pix_x, pix_y  out  DIM_W each  output coordinate (y=0 is top row)
- pix_eol  out  1  pixel is last in its row
- pix_last  out  1  pixel is last of frame
- done  out  1  frame complete
- pad_err  out  1  nonzero padding byte seen (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including readAddr; internal counters 0.
- stride = (3*width + 3) & ~3, 13-bit. Address arithmetic is 32-bit unsigned.
- Byte address for output pixel (x,y), byte k (k=0 B, 1 G, 2 R): DATA_OFFSET + (height-1-y)*stride + 3*x + k.
- FSM states: IDLE, RD, CAP, OUT, DONE (plus PAD_RD/PAD_CAP under the optional feature).
- IDLE:
  - On start=1: latch width/height; x=y=k=0.
  - If width==0 or height==0, go to DONE; otherwise go to RD.
- RD: readAddr = address(x,y,k); next state CAP.
- CAP:
  - Capture readdata[7:0] into B/G/R register selected by k.
  - If k<2: k++ and go to RD. If k==2: k=0 and go to OUT.
- Timing: 6 cycles per pixel fetch. pix_valid first asserts 6 cycles after the start edge.
- OUT:
  - pix_valid=1. pix_r/g/b/x/y/eol/last are held stable until pix_valid && pix_ready.
  - pix_eol = (x==width-1). pix_last = pix_eol && (y==height-1).
  - On handshake:
    - if last pixel, go to DONE;
    - else if eol, x=0, y++, go to RD;
    - else x++, go to RD.
  - No prefetch: one pixel in flight.
- DONE:
  - done=1, pix_valid=0.
  - start=1 restarts exactly as from IDLE (relatch dims); otherwise hold.
- readAddr holds its last value outside RD. Memory is read-only; no write port.
- start is ignored in RD/CAP/OUT. Dims are used only as latched copies, so input changes mid-frame have no effect.
- Reset mid-frame aborts immediately: pix_valid drops asynchronously, done=0.

Optional Feature:
- Macro: BMP_READER_PADDING_CHECK_EN.
- Defined:
  - After the handshake of each pix_eol pixel, read the row's pad bytes (stride - 3*width, 0..3) via PAD_RD/PAD_CAP, 2 cycles per byte, at addresses row_base + 3*width + p.
  - Any nonzero byte sets pad_err, which is sticky until reset or accepted start. Then continue to RD or DONE as normal.
- Undefined: padding is never read; no PAD states; pad_err tied 0.

Test Plan:
- Basic 2x2 readout, stride 8, default parameters.
  - Stimulus: width=2, height=2; mem[54..59]={01,02,03,04,05,06}, mem[62..67]={11,12,13,14,15,16}.
  - Response, in order:
    - (0,0) RGB=13,12,11;
    - (1,0) 16,15,14 with eol;
    - (0,1) 03,02,01;
    - (1,1) 06,05,04 with eol and last.
  - done=1 after the final handshake. readAddr never hits 60, 61, 68 or 69.
- Backpressure.
  - Stimulus: width=4, height=1 (stride 12, no pad); pix_ready=0 for 5 cycles while pix_valid=1.
  - Response: outputs stable throughout; exactly 4 pixels delivered, none duplicated.
- Zero dimension.
  - Stimulus: width=0, height=3, start pulse.
  - Response: done=1 on the next cycle; pix_valid never asserts; readAddr stays 0.
- Reset mid-frame and restart.
  - Stimulus: assert rst_n=0 mid-pixel in the 2x2 case, release, then start again.
  - Response: all outputs 0 during reset; full correct 4-pixel sequence after restart; first pix_valid 6 cycles after start.
- Restart from DONE.
  - Stimulus: after the 2x2 frame completes, start with width=1, height=1.
  - Response: done drops; one pixel from mem[54..56] with eol and last; done=1 again.
- Padding check (BMP_READER_PADDING_CHECK_EN defined).
  - Stimulus: width=1, height=1, mem[57]=AA.
  - Response: pad_err=1 after the pad reads. With mem[57..59]=0, pad_err stays 0.
